// File: rtl/scsi_ctrl_pkg.sv
// Shared state encoding and default timing constants for the BeebSCSI
// handshake controller.
package scsi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACK_HOLD,
        RELEASE
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/signal_synchroniser.sv
// Multi-flop synchroniser for one asynchronous input; all stages clear on
// synchronous reset.
module signal_synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic nReset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (!nReset) chain <= '0;
        else         chain <= {chain[STAGES-2:0], async_in};
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/scsi_handshake_controller.sv
// Turns host data-register accesses into a SCSI REQ/ACK handshake and drives
// the data inverter enables and the read-data latch strobe.
module scsi_handshake_controller
    import scsi_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clock,
    input  logic nReset,
    input  logic hostSel,
    input  logic hostRnW,
    input  logic scsiReq,
    input  logic scsiIo,
    input  logic scsiBsy,
    input  logic scsiRst,
    input  logic irqEnable,
    output logic scsiAck,
    output logic busOutOE,
    output logic hostOutOE,
    output logic dataLatchEn,
    output logic irq,
    output logic timeoutErr
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [5:0] raw_in;
    logic [5:0] sync_in;
    logic       sel_s, rnw_s, req_s, io_s, bsy_s, rst_s;

    assign raw_in = {hostSel, hostRnW, scsiReq, scsiIo, scsiBsy, scsiRst};
    assign {sel_s, rnw_s, req_s, io_s, bsy_s, rst_s} = sync_in;

    for (genvar i = 0; i < 6; i++) begin : g_sync
        signal_synchroniser #(.STAGES(SYNC_STAGES)) u_sync (
            .clock    (clock),
            .nReset   (nReset),
            .async_in (raw_in[i]),
            .sync_out (sync_in[i])
        );
    end

    state_t        state;
    logic [3:0]    setup_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          sel_d;
    logic          accept;

    assign accept = (state == IDLE) && sel_s && !sel_d && req_s;
    assign irq    = irqEnable & req_s & (state == IDLE);

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state       <= IDLE;
            setup_cnt   <= '0;
            tmo_cnt     <= '0;
            sel_d       <= 1'b0;
            scsiAck     <= 1'b0;
            busOutOE    <= 1'b0;
            hostOutOE   <= 1'b0;
            dataLatchEn <= 1'b0;
            timeoutErr  <= 1'b0;
        end else begin
            sel_d       <= sel_s;
            busOutOE    <= bsy_s & ~io_s & ~rst_s;
            hostOutOE   <= sel_s & rnw_s & io_s;
            dataLatchEn <= 1'b0;
            if (rst_s) begin
                state   <= IDLE;
                scsiAck <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state       <= SETUP;
                        setup_cnt   <= 4'(SETUP_CYC - 1);
                        dataLatchEn <= io_s;
                        timeoutErr  <= 1'b0;
                    end
                    SETUP: if (setup_cnt == '0) begin
                        state   <= ACK_HOLD;
                        scsiAck <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        setup_cnt <= setup_cnt - 4'd1;
                    end
                    // Abort on the edge where the count would reach TIMEOUT_CYC,
                    // so ACK is held for exactly TIMEOUT_CYC clocks.
                    ACK_HOLD: if (!req_s) begin
                        state <= RELEASE;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state      <= IDLE;
                        scsiAck    <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    // ACK drops on leaving RELEASE: REQ fall to ACK fall is
                    // SYNC_STAGES+2 clocks.
                    RELEASE: begin
                        state   <= IDLE;
                        scsiAck <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
